fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the RV32I core. It replaces the free-running program counter with a PC register that supports stall and redirect, and a valid/ready request/response interface to instruction memory. It presents each fetched instruction with its PC to decode through a valid/ready handshake. It sits between the instruction memory and instruction_decode, and takes redirects from the branch/jump logic.

Parameters:
XLEN, 32, address/PC width in bits
ILEN, 32, instruction width in bits
RESET_VECTOR, 32'h0000_0000, PC loaded on reset (must be 4-byte aligned)
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
redirect_valid  input  1  redirect request from branch/jump logic
redirect_pc  input  XLEN  target PC for redirect
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address
imem_rsp_valid  input  1  response data valid (one per accepted request, in order)
imem_rsp_data  input  ILEN  fetched instruction word
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts instruction
out_pc  output  XLEN  PC of out_instr
out_instr  output  ILEN  instruction word
fault  output  1  misaligned redirect fault, sticky

Behaviour:
- Reset (reset==0 at posedge): state=S_REQ; fetch_pc=RESET_VECTOR; drop=0; out_valid=0; out_pc=0; out_instr=NOP (32'h0000_0013); fault=0. imem_req_valid is 1 in the first cycle after reset is released.
- One outstanding request maximum. Responses are in order, and at most one arrives per accepted request.
- FSM states: S_REQ, S_WAIT, S_OUT, S_FAULT.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=fetch_pc.
  - If imem_req_ready: go to S_WAIT.
  - imem_req_valid is 0 in every other state.
- S_WAIT:
  - On imem_rsp_valid with drop=1: discard the response, clear drop, go to S_REQ.
  - On imem_rsp_valid with drop=0: out_instr<=imem_rsp_data, out_pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+PC_STEP (modulo 2^XLEN, wraps silently), go to S_OUT.
- S_OUT:
  - out_valid held at 1; out_pc and out_instr held stable until the handshake.
  - On out_valid && out_ready: out_valid<=0, go to S_REQ.
  - Fetch-to-output latency: at minimum 3 cycles per instruction (request, response, out handshake). Throughput is not pipelined in this generation.
- Redirect (redirect_valid==1) has priority over every other event in the same cycle:
  - Aligned target (redirect_pc[1:0]==0):
    - fetch_pc<=redirect_pc; out_valid<=0, and any pending out instruction is flushed.
    - From S_WAIT: if imem_rsp_valid arrives in the same cycle, discard it and go to S_REQ. Otherwise set drop=1 and stay in S_WAIT.
    - From S_REQ, S_OUT or S_FAULT: go to S_REQ and clear fault.
    - A redirect in S_REQ coincident with imem_req_ready: the accepted request is treated as stale. Set drop=1, go to S_WAIT.
  - Misaligned target: fault<=1, out_valid<=0, go to S_FAULT.
    - If a request is outstanding, set drop=1 first; S_FAULT swallows that response.
    - No requests are issued in S_FAULT. Only an aligned redirect or reset leaves it.
- Simultaneous out handshake and redirect: redirect wins. The handshaken instruction still counts as consumed by decode, and the flush applies to nothing further.
- Reset mid-operation overrides everything. Any later response to a pre-reset request is never expected; the memory is reset on the same signal.

Decomposition:
- Package fetch_pkg:
  - state enum {S_REQ, S_WAIT, S_OUT, S_FAULT}
  - NOP_INSTR = 32'h0000_0013
  - default RESET_VECTOR
- Single module with no sub-module. The PC register and FSM are tightly coupled.
- instruction_memory gains a valid/ready wrapper separately; it is not part of this block.

Test Plan:
- Reset released, memory always ready, 1-cycle response, out_ready=1 → out_pc sequence 0x0, 0x4, 0x8 with matching words; out_instr=0x0000_0013 and out_valid=0 during reset.
- out_ready held 0 for 5 cycles at PC 0x8 → out_valid, out_pc=0x8 and out_instr stable; no imem_req_valid; next request address 0xC after the handshake.
- Redirect to 0x100 while in S_WAIT for PC 0x4, response 2 cycles later → that response discarded; next request address 0x100; no out_valid for PC 0x4.
- Redirect to 0x102 → fault=1, imem_req_valid=0 for 10 cycles; then redirect to 0x200 → fault=0, request address 0x200.
- RESET_VECTOR=32'hFFFF_FFFC → after the first fetch, next request address 0x0 (wrap).
- Reset asserted in S_OUT → next cycle out_valid=0, fault=0, request address = RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch_unit and anything that talks to it.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_FAULT
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  function automatic logic pc_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with stall and redirect,
// one-outstanding valid/ready imem port, valid/ready out to decode.
// Ports: clk, reset (sync, active-low); redirect_valid/_pc from
// branch logic; imem_req_* / imem_rsp_* to instruction memory;
// out_valid/_ready/_pc/_instr to decode; fault (sticky misaligned).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            fault
);

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic            drop;

  logic aligned;
  logic req_fire;
  logic pend;
  logic pend_left;

  assign aligned  = pc_aligned(redirect_pc[1:0]);
  assign req_fire = (state == S_REQ) && imem_req_ready;

  // A response is still owed to us in WAIT, and in FAULT
  // while drop marks one that has not come back yet.
  assign pend = (state == S_WAIT) ||
                ((state == S_FAULT) && drop);

  // Still owed after this edge: either it was owed and did
  // not arrive now, or a request is being accepted now.
  assign pend_left = (pend && !imem_rsp_valid) || req_fire;

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = fetch_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_VECTOR;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= ILEN'(NOP_INSTR);
      fault     <= 1'b0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      drop      <= pend_left;
      if (aligned) begin
        fetch_pc <= redirect_pc;
        fault    <= 1'b0;
        // Wait out any stale response before re-requesting
        // so at most one request is ever in flight.
        state    <= pend_left ? S_WAIT : S_REQ;
      end else begin
        fault <= 1'b1;
        state <= S_FAULT;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              out_instr <= imem_rsp_data;
              out_pc    <= fetch_pc;
              out_valid <= 1'b1;
              fetch_pc  <= fetch_pc + XLEN'(PC_STEP);
              state     <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_FAULT: begin
          if (imem_rsp_valid && drop) begin
            drop <= 1'b0;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random traffic
// against a transaction-level model of the fetched PC stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;

  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        imem_req_valid2;
  logic        imem_req_ready2;
  logic [31:0] imem_req_addr2;
  logic        imem_rsp_valid2;
  logic [31:0] imem_rsp_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;
  logic        fault2;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fault(fault)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready2),
    .imem_req_addr(imem_req_addr2),
    .imem_rsp_valid(imem_rsp_valid2), .imem_rsp_data(imem_rsp_data2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_pc(out_pc2), .out_instr(out_instr2), .fault(fault2)
  );

  int n_assert = 0;
  int n_fail = 0;

  bit chk_en, rnd;
  bit d_out_ready, d_redirect;
  logic [31:0] d_rpc;
  int d_lat;

  bit pending;
  logic [31:0] paddr;
  int lat;
  bit pend2;
  logic [31:0] paddr2;
  logic [31:0] q2[$];
  logic [31:0] first_out2;
  bit got_out2;

  logic [31:0] exp_pc;
  bit exp_fault, redir_last;
  int wd;
  logic [31:0] hs_q[$];

  bit saw4, got_req;
  logic [31:0] first_req;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic start_model();
    chk_en = 1'b1;
    exp_pc = 32'h0;
    exp_fault = 1'b0;
    redir_last = 1'b0;
    wd = 0;
    hs_q.delete();
  endtask

  task automatic obs();
    @(negedge clk);
    if (chk_en) begin
      wd++;
      chk("fault", 32'(fault), 32'(exp_fault));
      if (exp_fault) begin
        chk("fault_no_req", 32'(imem_req_valid), 32'h0);
        chk("fault_no_out", 32'(out_valid), 32'h0);
        wd = 0;
      end
      if (out_valid) begin
        chk("out_pc", out_pc, exp_pc);
        chk("out_instr", out_instr, data_of(exp_pc));
      end
      if (redir_last) chk("flush", 32'(out_valid), 32'h0);
      chk("one_outstanding", 32'(imem_req_valid && pending), 32'h0);
      chk("watchdog", 32'(wd > 80), 32'h0);
      if (wd > 80) wd = 0;
    end
  endtask

  task automatic drv();
    bit rsp_now;
    out_ready = rnd ? ($urandom_range(3) != 0) : d_out_ready;
    if (rnd) begin
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(3) == 0)
        redirect_pc[1:0] = 2'($urandom_range(1, 3));
    end else begin
      redirect_valid = d_redirect;
      redirect_pc = d_rpc;
    end
    rsp_now = pending && (lat == 0);
    if (pending && lat > 0) lat--;
    imem_rsp_valid = rsp_now && reset;
    imem_rsp_data = rsp_now ? data_of(paddr) : $urandom;
    if (rsp_now) pending = 1'b0;
    imem_req_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
    if (imem_req_valid && imem_req_ready && reset) begin
      pending = 1'b1;
      paddr = imem_req_addr;
      lat = rnd ? int'($urandom_range(0, 3)) : d_lat;
    end
    if (!reset) pending = 1'b0;

    imem_rsp_valid2 = pend2 && reset;
    imem_rsp_data2 = data_of(paddr2);
    if (pend2) pend2 = 1'b0;
    if (out_valid2 && reset && !got_out2) begin
      got_out2 = 1'b1;
      first_out2 = out_pc2;
    end
    if (imem_req_valid2 && reset) begin
      pend2 = 1'b1;
      paddr2 = imem_req_addr2;
      q2.push_back(imem_req_addr2);
    end
    if (!reset) pend2 = 1'b0;

    if (chk_en && reset) begin
      if (out_valid && out_ready) begin
        hs_q.push_back(out_pc);
        exp_pc = exp_pc + 32'd4;
        wd = 0;
      end
      if (redirect_valid) begin
        if (redirect_pc[1:0] == 2'b00) begin
          exp_pc = redirect_pc;
          exp_fault = 1'b0;
        end else begin
          exp_fault = 1'b1;
        end
        wd = 0;
      end
      redir_last = redirect_valid;
    end
  endtask

  initial begin
    reset = 1'b0;
    chk_en = 1'b0; rnd = 1'b0;
    d_out_ready = 1'b1; d_redirect = 1'b0; d_rpc = '0; d_lat = 0;
    pending = 1'b0; paddr = '0; lat = 0;
    pend2 = 1'b0; paddr2 = '0; got_out2 = 1'b0; first_out2 = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    out_ready = 1'b0;
    redirect_valid2 = 1'b0; redirect_pc2 = '0;
    imem_req_ready2 = 1'b1; imem_rsp_valid2 = 1'b0;
    imem_rsp_data2 = '0; out_ready2 = 1'b1;
    exp_pc = '0; exp_fault = 1'b0; redir_last = 1'b0; wd = 0;

    repeat (3) begin obs(); drv(); end
    obs();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr, NOP_INSTR);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);

    reset = 1'b1;
    start_model();
    q2.delete();
    got_out2 = 1'b0;
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    drv();

    for (int i = 0; i < 40; i++) begin
      obs();
      if (out_valid && out_pc == 32'h8) break;
      drv();
    end
    chk("reach_pc8", 32'(out_valid && out_pc == 32'h8), 32'h1);
    chk("hs_count", 32'(hs_q.size()), 32'd2);
    if (hs_q.size() >= 2) begin
      chk("hs_pc0", hs_q[0], 32'h0);
      chk("hs_pc1", hs_q[1], 32'h4);
    end
    chk("wrap_req_count", 32'(q2.size() >= 2), 32'h1);
    if (q2.size() >= 2) begin
      chk("wrap_req0", q2[0], 32'hFFFF_FFFC);
      chk("wrap_req1", q2[1], 32'h0);
    end
    chk("wrap_out_pc", first_out2, 32'hFFFF_FFFC);

    d_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv();
      obs();
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_pc", out_pc, 32'h8);
      chk("hold_instr", out_instr, data_of(32'h8));
      chk("hold_no_req", 32'(imem_req_valid), 32'h0);
    end
    d_out_ready = 1'b1;
    drv();
    obs();
    chk("next_req_valid", 32'(imem_req_valid), 32'h1);
    chk("next_req_addr", imem_req_addr, 32'hC);

    d_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv();
      obs();
      if (out_valid) break;
    end
    chk("reach_pc_c", 32'(out_valid && out_pc == 32'hC), 32'h1);
    reset = 1'b0;
    chk_en = 1'b0;
    drv();
    obs();
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_fault", 32'(fault), 32'h0);
    chk("mid_rst_req_addr", imem_req_addr, 32'h0);
    chk("mid_rst_instr", out_instr, NOP_INSTR);

    reset = 1'b1;
    start_model();
    d_out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (imem_req_valid && imem_req_addr == 32'h4) break;
      drv();
      obs();
    end
    chk("reach_req4", 32'(imem_req_valid && imem_req_addr == 32'h4), 32'h1);
    d_lat = 2;
    drv();
    obs();
    chk("wait4_no_req", 32'(imem_req_valid), 32'h0);
    d_redirect = 1'b1;
    d_rpc = 32'h100;
    drv();
    d_redirect = 1'b0;
    d_lat = 0;
    saw4 = 1'b0; got_req = 1'b0; first_req = '0;
    for (int i = 0; i < 12; i++) begin
      obs();
      if (out_valid && out_pc == 32'h4) saw4 = 1'b1;
      if (imem_req_valid && !got_req) begin
        got_req = 1'b1;
        first_req = imem_req_addr;
      end
      drv();
    end
    chk("redir_req_addr", first_req, 32'h100);
    chk("redir_no_pc4", 32'(saw4), 32'h0);

    obs();
    d_redirect = 1'b1;
    d_rpc = 32'h102;
    drv();
    d_redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs();
      chk("mis_fault", 32'(fault), 32'h1);
      chk("mis_no_req", 32'(imem_req_valid), 32'h0);
      drv();
    end
    obs();
    d_redirect = 1'b1;
    d_rpc = 32'h200;
    drv();
    d_redirect = 1'b0;
    obs();
    chk("recover_fault", 32'(fault), 32'h0);
    chk("recover_req_valid", 32'(imem_req_valid), 32'h1);
    chk("recover_req_addr", imem_req_addr, 32'h200);

    rnd = 1'b1;
    repeat (3000) begin
      drv();
      obs();
    end
    rnd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
